// File: rtl/stage_progress_ctrl.sv
// Three-stage reflex round sequencer: drives cumulative stage-cleared lights,
// stage index and play/win/lose status from start/clear/fail pulses and timers.
module stage_progress_ctrl #(
  parameter int STAGE_TIMEOUT = 50000000,
  parameter int PAUSE_CYCLES  = 25000000,
  parameter int RESULT_HOLD   = 100000000,
  parameter int CNT_W         = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stage_clear,
  input  logic       fail,
  output logic       light1,
  output logic       light2,
  output logic       light3,
  output logic [1:0] stage,
  output logic       playing,
  output logic       win,
  output logic       lose
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PLAY  = 3'd1;
  localparam logic [2:0] S_PAUSE = 3'd2;
  localparam logic [2:0] S_WIN   = 3'd3;
  localparam logic [2:0] S_LOSE  = 3'd4;

  localparam logic [CNT_W-1:0] PLAY_LAST  = CNT_W'(STAGE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RESULT_HOLD - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      light1  <= 1'b0;
      light2  <= 1'b0;
      light3  <= 1'b0;
      stage   <= 2'd0;
      playing <= 1'b0;
      win     <= 1'b0;
      lose    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          // Lights hold so the finished round stays on the display.
          if (start) begin
            light1  <= 1'b0;
            light2  <= 1'b0;
            light3  <= 1'b0;
            stage   <= 2'd1;
            playing <= 1'b1;
            state   <= S_PLAY;
          end
        end

        S_PLAY: begin
          if (fail) begin
            state   <= S_LOSE;
            cnt     <= '0;
            playing <= 1'b0;
            lose    <= 1'b1;
          end else if (stage_clear) begin
            cnt <= '0;
            case (stage)
              2'd1:    light1 <= 1'b1;
              2'd2:    light2 <= 1'b1;
              2'd3:    light3 <= 1'b1;
              default: ;
            endcase
            if (stage == 2'd3) begin
              state   <= S_WIN;
              playing <= 1'b0;
              win     <= 1'b1;
            end else begin
              state <= S_PAUSE;
            end
          end else if (cnt == PLAY_LAST) begin
            state   <= S_LOSE;
            cnt     <= '0;
            playing <= 1'b0;
            lose    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_PAUSE: begin
          if (cnt == PAUSE_LAST) begin
            state <= S_PLAY;
            cnt   <= '0;
            stage <= stage + 2'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_WIN, S_LOSE: begin
          if (cnt == HOLD_LAST) begin
            state <= S_IDLE;
            cnt   <= '0;
            stage <= 2'd0;
            win   <= 1'b0;
            lose  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          // Unused encodings fall back to a clean idle.
          state   <= S_IDLE;
          cnt     <= '0;
          light1  <= 1'b0;
          light2  <= 1'b0;
          light3  <= 1'b0;
          stage   <= 2'd0;
          playing <= 1'b0;
          win     <= 1'b0;
          lose    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stage_progress_ctrl.sv
// Directed bench for stage_progress_ctrl with short timers (8/4/6 cycles).
module tb_stage_progress_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stage_clear;
  logic       fail;
  logic       light1, light2, light3;
  logic [1:0] stage;
  logic       playing, win, lose;

  int checks = 0;
  int errors = 0;

  stage_progress_ctrl #(
    .STAGE_TIMEOUT(8),
    .PAUSE_CYCLES (4),
    .RESULT_HOLD  (6),
    .CNT_W        (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stage_clear(stage_clear),
    .fail       (fail),
    .light1     (light1),
    .light2     (light2),
    .light3     (light3),
    .stage      (stage),
    .playing    (playing),
    .win        (win),
    .lose       (lose)
  );

  always #5 clk = ~clk;

  // Status packed as {stage[1:0], playing, win, lose, light3, light2, light1}.
  function automatic logic [7:0] status();
    return {stage, playing, win, lose, light3, light2, light1};
  endfunction

  function automatic logic [7:0] exp_st(input logic [1:0] stg, input logic pl,
                                        input logic w, input logic l,
                                        input logic [2:0] lights);
    return {stg, pl, w, l, lights};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stage_clear = 1'b0; fail = 1'b0;
    #12;
    check("reset_state", status(), exp_st(2'd0, 1'b0, 1'b0, 1'b0, 3'b000));
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Reset during PLAY with light1 set
    start = 1'b1; tick(1); start = 1'b0;
    check("start_play", status(), exp_st(2'd1, 1'b1, 1'b0, 1'b0, 3'b000));
    stage_clear = 1'b1; tick(1); stage_clear = 1'b0;
    tick(4);
    check("pre_reset_play2", status(), exp_st(2'd2, 1'b1, 1'b0, 1'b0, 3'b001));
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", status(), exp_st(2'd0, 1'b0, 1'b0, 1'b0, 3'b000));
    tick(1);
    rst_n = 1'b1;
    tick(1);
    check("post_reset_idle", status(), exp_st(2'd0, 1'b0, 1'b0, 1'b0, 3'b000));

    // Full win round, with ignored events in PAUSE/PLAY/WIN
    start = 1'b1; tick(1); start = 1'b0;
    check("fresh_round", status(), exp_st(2'd1, 1'b1, 1'b0, 1'b0, 3'b000));
    tick(2);
    stage_clear = 1'b1; tick(1); stage_clear = 1'b0;
    check("clear1", status(), exp_st(2'd1, 1'b1, 1'b0, 1'b0, 3'b001));
    tick(3);
    check("pause1_hold", status(), exp_st(2'd1, 1'b1, 1'b0, 1'b0, 3'b001));
    tick(1);
    check("stage2_enter", status(), exp_st(2'd2, 1'b1, 1'b0, 1'b0, 3'b001));
    tick(1);
    stage_clear = 1'b1; tick(1); stage_clear = 1'b0;
    check("clear2", status(), exp_st(2'd2, 1'b1, 1'b0, 1'b0, 3'b011));
    fail = 1'b1; start = 1'b1; tick(1); fail = 1'b0; start = 1'b0;
    stage_clear = 1'b1; tick(1); stage_clear = 1'b0;
    tick(1);
    check("pause_ignores", status(), exp_st(2'd2, 1'b1, 1'b0, 1'b0, 3'b011));
    tick(1);
    check("stage3_enter", status(), exp_st(2'd3, 1'b1, 1'b0, 1'b0, 3'b011));
    start = 1'b1; tick(1); start = 1'b0;
    check("start_in_play", status(), exp_st(2'd3, 1'b1, 1'b0, 1'b0, 3'b011));
    stage_clear = 1'b1; tick(1); stage_clear = 1'b0;
    check("win_enter", status(), exp_st(2'd3, 1'b0, 1'b1, 1'b0, 3'b111));
    start = 1'b1; fail = 1'b1; tick(1); start = 1'b0; fail = 1'b0;
    tick(4);
    check("win_hold_last", status(), exp_st(2'd3, 1'b0, 1'b1, 1'b0, 3'b111));
    tick(1);
    check("win_to_idle", status(), exp_st(2'd0, 1'b0, 1'b0, 1'b0, 3'b111));
    tick(2);
    check("idle_keeps_lights", status(), exp_st(2'd0, 1'b0, 1'b0, 1'b0, 3'b111));

    // Timeout round
    start = 1'b1; tick(1); start = 1'b0;
    check("timeout_start", status(), exp_st(2'd1, 1'b1, 1'b0, 1'b0, 3'b000));
    tick(7);
    check("timeout_not_yet", status(), exp_st(2'd1, 1'b1, 1'b0, 1'b0, 3'b000));
    tick(1);
    check("timeout_lose", status(), exp_st(2'd1, 1'b0, 1'b0, 1'b1, 3'b000));
    tick(5);
    check("lose_hold_last", status(), exp_st(2'd1, 1'b0, 1'b0, 1'b1, 3'b000));
    tick(1);
    check("lose_to_idle", status(), exp_st(2'd0, 1'b0, 1'b0, 1'b0, 3'b000));

    // fail beats stage_clear in the same cycle
    start = 1'b1; tick(1); start = 1'b0;
    stage_clear = 1'b1; tick(1); stage_clear = 1'b0;
    tick(4);
    check("prio_stage2", status(), exp_st(2'd2, 1'b1, 1'b0, 1'b0, 3'b001));
    fail = 1'b1; stage_clear = 1'b1; tick(1); fail = 1'b0; stage_clear = 1'b0;
    check("fail_priority", status(), exp_st(2'd2, 1'b0, 1'b0, 1'b1, 3'b001));
    tick(6);
    check("prio_idle", status(), exp_st(2'd0, 1'b0, 1'b0, 1'b0, 3'b001));

    // Clear on the last allowed cycle counts as a clear
    start = 1'b1; tick(1); start = 1'b0;
    tick(7);
    stage_clear = 1'b1; tick(1); stage_clear = 1'b0;
    check("clear_at_limit", status(), exp_st(2'd1, 1'b1, 1'b0, 1'b0, 3'b001));
    tick(4);
    check("limit_stage2", status(), exp_st(2'd2, 1'b1, 1'b0, 1'b0, 3'b001));
    tick(8);
    check("stage2_timeout", status(), exp_st(2'd2, 1'b0, 1'b0, 1'b1, 3'b001));
    tick(6);
    check("final_idle", status(), exp_st(2'd0, 1'b0, 1'b0, 1'b0, 3'b001));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
